// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the target (and its initiator counterpart).
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 32;

  // CPOL=0, CPHA=0: SCK idles low, data sampled on rising edge, shifted on falling edge.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;
  localparam logic [1:0] ST_WORD_DONE = 2'd3;

  // Bit counter width: must be able to hold the value DATA_WIDTH itself.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// Pin and parallel-port bundle of the SPI target. The target uses the slave
// modport; the initiator/consumer side (or a bench) uses the master modport.
interface spi_target_if import spi_pkg::*; #(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) ();

  logic                  sck_i;
  logic                  cs_n_i;
  logic                  mosi_i;
  logic                  miso_o;
  logic                  miso_oe_o;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic                  rx_overrun_o;
  logic                  tx_underrun_o;
  logic                  frame_err_o;

  modport slave (
    input  sck_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i, rx_ready_i,
    output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           rx_overrun_o, tx_underrun_o, frame_err_o
  );

  modport master (
    output sck_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i, rx_ready_i,
    input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           rx_overrun_o, tx_underrun_o, frame_err_o
  );

endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a
// previous-sample flop that yields single-cycle rise/fall strobes.
// STAGES must be at least 2.
module spi_in_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw pin through the synchroniser chain and keep the last synced sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder, MSB first. All SPI pins are oversampled on clk_i;
// received words appear on a valid/ready port and a one-word TX holding
// register supplies the word returned on MISO for each SPI word.
module spi_target import spi_pkg::*; #(
  parameter int   DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_FILL   = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst,
  spi_target_if.slave  bus
);

  localparam int              CW        = bit_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]   WORD_BITS = CW'(DATA_WIDTH);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  logic [1:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_overrun_q;
  logic                  tx_underrun_q;
  logic                  frame_err_q;

  logic load_take;
  logic tx_accept;
  logic word_done;
  logic rx_accept;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk   (clk_i),
    .rst   (rst),
    .din   (bus.sck_i),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // The chip-select chain resets to 0 ("selected") on purpose: if reset is
  // released mid-frame, no cs_fall can be produced until cs_n has been seen
  // high again, so the rest of the interrupted frame is ignored.
  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk   (clk_i),
    .rst   (rst),
    .din   (bus.cs_n_i),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk_i),
    .rst   (rst),
    .din   (bus.mosi_i),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

  // A write is also accepted while full when LOAD drains the old word in the
  // same cycle, so the new word lands in the holding register behind it.
  assign load_take = (state == ST_LOAD) && hold_full;
  assign tx_accept = bus.tx_valid_i && (!hold_full || load_take);
  assign word_done = (state == ST_WORD_DONE);
  assign rx_accept = rx_valid_q && bus.rx_ready_i;

  // TX holding register: filled by the parallel port, drained by LOAD.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (tx_accept) begin
      hold_full <= 1'b1;
      hold_data <= bus.tx_data_i;
    end else if (load_take) begin
      hold_full <= 1'b0;
    end
  end

  // Word sequencer: loads MISO, shifts both directions and detects aborted words.
  // A MISO shift is skipped while no bit of the current word has been sampled,
  // because that falling edge closes the previous word of a back-to-back burst.
  // cs_n rising before any bit of a word was sampled is a normal end of frame.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      tx_shift      <= {DATA_WIDTH{IDLE_FILL}};
      rx_shift      <= '0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          bit_cnt <= '0;
          if (hold_full) begin
            tx_shift <= hold_data;
          end else begin
            tx_shift      <= {DATA_WIDTH{IDLE_FILL}};
            tx_underrun_q <= 1'b1;
          end
          state <= cs_rise ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_IDLE;
            if (bit_cnt != '0) frame_err_q <= 1'b1;
          end else begin
            if (sck_fall && (bit_cnt != '0)) begin
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], IDLE_FILL};
            end
            if (sck_rise) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_level};
              bit_cnt  <= bit_cnt + CW'(1);
              if (bit_cnt == WORD_BITS - CW'(1)) state <= ST_WORD_DONE;
            end
          end
        end
        ST_WORD_DONE: begin
          state <= cs_level ? ST_IDLE : ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RX output register: publish completed words and flag unaccepted overwrites.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;
      if (word_done) begin
        rx_data_q    <= rx_shift;
        rx_valid_q   <= 1'b1;
        rx_overrun_q <= rx_valid_q && !bus.rx_ready_i;
      end else if (rx_accept) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.miso_o        = tx_shift[DATA_WIDTH-1];
  assign bus.miso_oe_o     = (state != ST_IDLE);
  assign bus.tx_ready_o    = !hold_full;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.rx_overrun_o  = rx_overrun_q;
  assign bus.tx_underrun_o = tx_underrun_q;
  assign bus.frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: acts as SPI initiator at clk/8 and checks the target
// against a word-level model of the TX holding register and RX port.
module tb_spi_target;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_target_if #(.DATA_WIDTH(32)) bus ();

  spi_target #(
    .DATA_WIDTH  (32),
    .SYNC_STAGES (2),
    .IDLE_FILL   (1'b0)
  ) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  bit          model_hold_full = 1'b0;
  logic [31:0] model_hold_data = '0;
  bit          model_rx_pending = 1'b0;
  logic [31:0] exp_rx[$];
  int          exp_underrun = 0;
  int          exp_overrun  = 0;
  int          exp_frame_err = 0;
  int          seen_underrun = 0;
  int          seen_overrun  = 0;
  int          seen_frame_err = 0;
  logic [31:0] last_miso = '0;

  logic        rst_prev = 1'b0;
  logic        valid_prev = 1'b0;
  logic [31:0] data_prev = '0;
  logic        under_prev = 1'b0;
  logic        over_prev = 1'b0;
  logic        fe_prev = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    model_hold_full  = 1'b0;
    model_rx_pending = 1'b0;
    exp_rx.delete();
  endtask

  task automatic check_counts(input string tag);
    checkOutput({tag, "_underrun_count"}, seen_underrun, exp_underrun);
    checkOutput({tag, "_overrun_count"}, seen_overrun, exp_overrun);
    checkOutput({tag, "_frame_err_count"}, seen_frame_err, exp_frame_err);
  endtask

  task automatic push_tx(input logic [31:0] data);
    int n = 0;
    while (!bus.tx_ready_o && n < 50) begin
      wait_clk(1);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_tx_timeout actual=busy required=ready");
    end
    bus.tx_data_i  = data;
    bus.tx_valid_i = 1'b1;
    wait_clk(1);
    bus.tx_valid_i = 1'b0;
    model_hold_full = 1'b1;
    model_hold_data = data;
  endtask

  // One cs_n-low frame of num_words words. abort_after>0 stops after that many
  // bits; reset_at>0 pulses rst before that bit; load_write drives a TX write
  // during the LOAD cycle of the first word.
  task automatic applyStimulus(input logic [31:0] word0, input logic [31:0] word1,
                               input int num_words, input int abort_after,
                               input int reset_at, input bit load_write,
                               input logic [31:0] load_data);
    logic [31:0] word;
    logic [31:0] exp_miso;
    logic [31:0] got_miso;
    bit          void_frame;
    int          n_bits;
    int          n;
    void_frame = 1'b0;
    got_miso   = '0;
    bus.cs_n_i = 1'b0;
    if (load_write) begin
      n = 0;
      while (!bus.miso_oe_o && n < 20) begin
        wait_clk(1);
        n++;
      end
      if (n >= 20) begin
        checks++;
        failures++;
        $display("[TB] FAIL load_wait_timeout actual=idle required=selected");
      end
      bus.tx_data_i  = load_data;
      bus.tx_valid_i = 1'b1;
      wait_clk(1);
      bus.tx_valid_i = 1'b0;
    end
    for (int w = 0; w < num_words; w++) begin
      word = (w == 0) ? word0 : word1;
      if (model_hold_full) begin
        exp_miso        = model_hold_data;
        model_hold_full = 1'b0;
      end else begin
        exp_miso = '0;
        exp_underrun++;
      end
      if (w == 0 && load_write) begin
        model_hold_full = 1'b1;
        model_hold_data = load_data;
      end
      n_bits = (abort_after > 0) ? abort_after : 32;
      for (int i = 0; i < n_bits; i++) begin
        bus.mosi_i = word[31-i];
        wait_clk((w == 0 && i == 0) ? 8 : 4);
        if (reset_at > 0 && i == reset_at) begin
          rst = 1'b1;
          wait_clk(3);
          rst = 1'b0;
          void_frame = 1'b1;
          model_reset();
        end
        got_miso[31-i] = bus.miso_o;
        bus.sck_i = 1'b1;
        if (i != n_bits - 1) begin
          wait_clk(4);
          bus.sck_i = 1'b0;
        end
      end
      if (abort_after > 0) begin
        wait_clk(4);
        bus.sck_i = 1'b0;
        wait_clk(4);
        bus.cs_n_i = 1'b1;
        if (!void_frame) exp_frame_err++;
      end else if (!void_frame) begin
        exp_rx.push_back(word);
        if (!bus.rx_ready_i && model_rx_pending) exp_overrun++;
        model_rx_pending = !bus.rx_ready_i;
        checkOutput("miso_word", got_miso, exp_miso);
        last_miso = got_miso;
      end
      if (w != num_words - 1) begin
        wait_clk(4);
        bus.sck_i = 1'b0;
      end
    end
    if (abort_after == 0) begin
      wait_clk(1);
      bus.cs_n_i = 1'b1;
      wait_clk(3);
      bus.sck_i = 1'b0;
    end
    wait_clk(8);
  endtask

  // Per-cycle compare: reset values, every newly published RX word, pulse widths.
  always @(negedge clk) begin
    if (rst && rst_prev) begin
      checkOutput("reset_outputs",
                  {bus.miso_o, bus.miso_oe_o, bus.tx_ready_o, bus.rx_valid_o,
                   bus.rx_overrun_o, bus.tx_underrun_o, bus.frame_err_o, bus.rx_data_o},
                  {7'b0010000, 32'h0});
    end else if (!rst) begin
      if (bus.rx_valid_o && (!valid_prev || bus.rx_data_o !== data_prev)) begin
        if (exp_rx.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rx_unexpected_word actual=%0h required=none", bus.rx_data_o);
        end else begin
          checkOutput("rx_word", bus.rx_data_o, exp_rx.pop_front());
        end
      end
      if (bus.tx_underrun_o) begin
        seen_underrun++;
        checkOutput("underrun_pulse_width", under_prev, 0);
      end
      if (bus.rx_overrun_o) begin
        seen_overrun++;
        checkOutput("overrun_pulse_width", over_prev, 0);
      end
      if (bus.frame_err_o) begin
        seen_frame_err++;
        checkOutput("frame_err_pulse_width", fe_prev, 0);
      end
    end
    rst_prev   = rst;
    valid_prev = bus.rx_valid_o;
    data_prev  = bus.rx_data_o;
    under_prev = bus.tx_underrun_o;
    over_prev  = bus.rx_overrun_o;
    fe_prev    = bus.frame_err_o;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.sck_i      = 1'b0;
    bus.cs_n_i     = 1'b1;
    bus.mosi_i     = 1'b0;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b1;
    wait_clk(4);
    checkOutput("reset_tx_ready", bus.tx_ready_o, 1);
    checkOutput("reset_miso_oe", bus.miso_oe_o, 0);
    rst = 1'b0;
    wait_clk(4);

    $display("[TB] test 1: queued TX word, normal frame");
    push_tx(32'hA5A5_0F0F);
    checkOutput("t1_tx_ready_after_push", bus.tx_ready_o, 0);
    applyStimulus(32'h1234_5678, 32'h0, 1, 0, 0, 1'b0, 32'h0);
    checkOutput("t1_rx_data", bus.rx_data_o, 32'h1234_5678);
    checkOutput("t1_miso_literal", last_miso, 32'hA5A5_0F0F);
    checkOutput("t1_tx_ready", bus.tx_ready_o, 1);
    check_counts("t1");

    $display("[TB] test 2: underrun frame");
    applyStimulus(32'hCAFE_F00D, 32'h0, 1, 0, 0, 1'b0, 32'h0);
    checkOutput("t2_miso_literal", last_miso, 32'h0);
    checkOutput("t2_rx_data", bus.rx_data_o, 32'hCAFE_F00D);
    checkOutput("t2_underrun_literal", seen_underrun, 1);
    check_counts("t2");

    $display("[TB] test 3: back-to-back words, consumer stalled");
    bus.rx_ready_i = 1'b0;
    applyStimulus(32'h0BAD_F00D, 32'h7654_3210, 2, 0, 0, 1'b0, 32'h0);
    checkOutput("t3_rx_valid", bus.rx_valid_o, 1);
    checkOutput("t3_rx_data", bus.rx_data_o, 32'h7654_3210);
    checkOutput("t3_overrun_literal", seen_overrun, 1);
    check_counts("t3");
    bus.rx_ready_i   = 1'b1;
    model_rx_pending = 1'b0;
    wait_clk(2);
    checkOutput("t3_rx_drained", bus.rx_valid_o, 0);

    $display("[TB] test 4: cs_n rises after 17 bits");
    push_tx(32'h1111_2222);
    applyStimulus(32'hF0F0_F0F0, 32'h0, 1, 17, 0, 1'b0, 32'h0);
    checkOutput("t4_frame_err_literal", seen_frame_err, 1);
    checkOutput("t4_rx_valid", bus.rx_valid_o, 0);
    checkOutput("t4_rx_data_kept", bus.rx_data_o, 32'h7654_3210);
    checkOutput("t4_idle", bus.miso_oe_o, 0);
    checkOutput("t4_tx_consumed", bus.tx_ready_o, 1);
    check_counts("t4");

    $display("[TB] test 5: reset at bit 10, then full frame");
    applyStimulus(32'h1357_2468, 32'h0, 1, 0, 10, 1'b0, 32'h0);
    checkOutput("t5_rx_valid_after_reset", bus.rx_valid_o, 0);
    checkOutput("t5_rx_data_after_reset", bus.rx_data_o, 32'h0);
    applyStimulus(32'hDEAD_BEEF, 32'h0, 1, 0, 0, 1'b0, 32'h0);
    checkOutput("t5_rx_data", bus.rx_data_o, 32'hDEAD_BEEF);
    check_counts("t5");

    $display("[TB] test 6: TX write during LOAD with holding register full");
    push_tx(32'hA1A1_A1A1);
    applyStimulus(32'h2468_ACE0, 32'h0, 1, 0, 0, 1'b1, 32'hB2B2_B2B2);
    checkOutput("t6_old_word_sent", last_miso, 32'hA1A1_A1A1);
    checkOutput("t6_tx_ready_held", bus.tx_ready_o, 0);
    applyStimulus(32'h1111_0000, 32'h0, 1, 0, 0, 1'b0, 32'h0);
    checkOutput("t6_new_word_sent", last_miso, 32'hB2B2_B2B2);
    checkOutput("t6_tx_ready_final", bus.tx_ready_o, 1);
    checkOutput("t6_rx_data", bus.rx_data_o, 32'h1111_0000);
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
